// File: rtl/float_copro_pkg.sv
// Shared types and constants for the float coprocessor dispatch front-end.
package float_copro_pkg;

  localparam logic [10:0] OP_ADD = 11'd0;
  localparam logic [10:0] OP_SUB = 11'd1;
  localparam logic [10:0] OP_MUL = 11'd2;
  localparam logic [10:0] OP_MAX = 11'd2;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    FLUSH,
    IDLE,
    ISSUE,
    WAIT,
    ACK,
    RET
  } state_t;

  typedef struct packed {
    logic [10:0] opcode;
    logic [31:0] op0;
    logic [31:0] op1;
  } req_t;

  function automatic logic op_legal(input logic [10:0] op);
    return op <= OP_MAX;
  endfunction

endpackage

// File: rtl/float_copro_dispatch_fifo.sv
// Request FIFO for the dispatch front-end: in-order, power-of-2 depth,
// synchronous clear on reset.
module copro_req_fifo
  import float_copro_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  req_t wdata,
  output req_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = cnt == (AW+1)'(DEPTH);
  assign empty   = cnt == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

endmodule

// File: rtl/float_copro_dispatch.sv
// Dispatch front-end between the CPU custom-instruction port and float_copro.
// Define DISPATCH_TIMEOUT_EN to add an 8-bit WAIT watchdog returning qNaN.
module float_copro_dispatch
  import float_copro_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int T_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic [10:0] cpu_opcode,
  input  logic [31:0] cpu_op0,
  input  logic [31:0] cpu_op1,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_err,
  output logic        copro_valid,
  output logic [10:0] copro_opcode,
  output logic [31:0] copro_op0,
  output logic [31:0] copro_op1,
  input  logic        copro_complete,
  input  logic [31:0] copro_result,
  output logic        copro_accept
);

  localparam int FW = $clog2(T_MAX + 1);

  state_t        state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          rv_q, rv_d;
  logic          re_q, re_d;
  logic [31:0]   rd_q, rd_d;
  req_t          iss_q, iss_d;
  logic          acc_q;
  logic          push, pop, full, empty;
  req_t          head;
`ifdef DISPATCH_TIMEOUT_EN
  logic [7:0]    wd_q, wd_d;
`endif

  assign cpu_ready    = !full && (state_q != FLUSH);
  assign push         = cpu_valid && cpu_ready;
  assign copro_valid  = state_q == ISSUE;
  assign copro_opcode = iss_q.opcode;
  assign copro_op0    = iss_q.op0;
  assign copro_op1    = iss_q.op1;
  assign res_valid    = rv_q;
  assign res_err      = re_q;
  assign res_data     = rd_q;

  copro_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ('{opcode: cpu_opcode, op0: cpu_op0, op1: cpu_op1}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d      = state_q;
    fcnt_d       = fcnt_q;
    rv_d         = rv_q;
    re_d         = re_q;
    rd_d         = rd_q;
    iss_d        = iss_q;
    pop          = 1'b0;
    copro_accept = 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
    wd_d         = wd_q;
`endif
    unique case (state_q)
      FLUSH: begin
        // copro has no reset: swallow any stale result it still holds
        copro_accept = copro_complete && !acc_q;
        if (rv_q && res_ready) begin
          rv_d = 1'b0;
          re_d = 1'b0;
        end
        fcnt_d = fcnt_q + 1'b1;
        if (fcnt_q == FW'(T_MAX - 1)) begin
          fcnt_d  = '0;
          state_d = rv_d ? RET : IDLE;
        end
      end
      IDLE: begin
        if (!empty && !copro_complete) begin
          pop = 1'b1;
          if (op_legal(head.opcode)) begin
            iss_d   = head;
            state_d = ISSUE;
          end else begin
            rv_d    = 1'b1;
            re_d    = 1'b1;
            rd_d    = '0;
            state_d = RET;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef DISPATCH_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      WAIT: begin
        if (copro_complete) begin
          copro_accept = 1'b1;
          rd_d         = copro_result;
          state_d      = ACK;
        end
`ifdef DISPATCH_TIMEOUT_EN
        else if (wd_q == 8'd255) begin
          rv_d    = 1'b1;
          re_d    = 1'b1;
          rd_d    = QNAN;
          fcnt_d  = '0;
          state_d = FLUSH;
        end else begin
          wd_d = wd_q + 8'd1;
        end
`endif
      end
      ACK: begin
        rv_d    = 1'b1;
        re_d    = 1'b0;
        state_d = RET;
      end
      RET: begin
        if (res_ready) begin
          rv_d    = 1'b0;
          re_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = FLUSH;
    endcase
    if (!rst_n) copro_accept = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      fcnt_q  <= '0;
      rv_q    <= 1'b0;
      re_q    <= 1'b0;
      rd_q    <= '0;
      iss_q   <= '0;
      acc_q   <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      rv_q    <= rv_d;
      re_q    <= re_d;
      rd_q    <= rd_d;
      iss_q   <= iss_d;
      acc_q   <= copro_accept;
`ifdef DISPATCH_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_float_copro_dispatch.sv
// Directed bench for float_copro_dispatch with a behavioural copro model
// that holds complete until accept and has no reset.
module tb_float_copro_dispatch;

  localparam int DEPTH = 4;
  localparam int T_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_valid = 1'b0;
  logic        cpu_ready;
  logic [10:0] cpu_opcode = '0;
  logic [31:0] cpu_op0 = '0;
  logic [31:0] cpu_op1 = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_err;
  logic        copro_valid;
  logic [10:0] copro_opcode;
  logic [31:0] copro_op0;
  logic [31:0] copro_op1;
  logic        copro_complete = 1'b0;
  logic [31:0] copro_result = '0;
  logic        copro_accept;

  int checks = 0;
  int failures = 0;
  int n_val = 0;
  int n_acc = 0;
  int n_viol = 0;
  int cp_lat = 3;
  int cp_cnt = 0;
  logic [10:0] cp_op = '0;
  logic [31:0] cp_a = '0;
  logic [31:0] cp_b = '0;

  always #5 clk = ~clk;

  float_copro_dispatch #(.DEPTH(DEPTH), .T_MAX(T_MAX)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_valid      (cpu_valid),
    .cpu_ready      (cpu_ready),
    .cpu_opcode     (cpu_opcode),
    .cpu_op0        (cpu_op0),
    .cpu_op1        (cpu_op1),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err),
    .copro_valid    (copro_valid),
    .copro_opcode   (copro_opcode),
    .copro_op0      (copro_op0),
    .copro_op1      (copro_op1),
    .copro_complete (copro_complete),
    .copro_result   (copro_result),
    .copro_accept   (copro_accept)
  );

  function automatic logic [31:0] fmodel(input logic [10:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    if (op == 11'd0 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    if (op == 11'd0 && a == 32'h3F800000 && b == 32'h3F800000) return 32'h40000000;
    if (op == 11'd0 && a == 32'h40000000 && b == 32'h40000000) return 32'h40800000;
    if (op == 11'd0 && a == 32'h40000000 && b == 32'h40800000) return 32'h40C00000;
    if (op == 11'd0 && a == 32'h40800000 && b == 32'h40800000) return 32'h41000000;
    if (op == 11'd1 && a == 32'h40A00000 && b == 32'h40400000) return 32'h40000000;
    if (op == 11'd2 && a == 32'h40000000 && b == 32'h40800000) return 32'h41000000;
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk) begin
    if (copro_valid) n_val++;
    if (copro_accept) n_acc++;
    if (copro_valid && (copro_accept || copro_complete)) n_viol++;
    if (copro_accept) copro_complete <= 1'b0;
    if (cp_cnt > 0) begin
      cp_cnt <= cp_cnt - 1;
      if (cp_cnt == 1) begin
        copro_complete <= 1'b1;
        copro_result   <= fmodel(cp_op, cp_a, cp_b);
      end
    end
    if (copro_valid) begin
      cp_cnt <= cp_lat;
      cp_op  <= copro_opcode;
      cp_a   <= copro_op0;
      cp_b   <= copro_op1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [10:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int n = 0;
    cpu_valid  = 1'b1;
    cpu_opcode = op;
    cpu_op0    = a;
    cpu_op1    = b;
    while (!cpu_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      failures++;
      $display("FAIL push_ready: cpu_ready stayed %0b, required 1", cpu_ready);
    end
    tick();
    cpu_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    while (!res_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!res_valid) begin
      failures++;
      $display("FAIL wait_res: res_valid=0 after %0d cycles, required 1", lat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++; $display("FAIL rst_cpu_ready: got %0b want 0", cpu_ready);
    end
    checks++;
    if ({res_valid, res_err, res_data} !== 34'd0) begin
      failures++; $display("FAIL rst_res: got v=%0b e=%0b d=%h want 0", res_valid, res_err, res_data);
    end
    checks++;
    if ({copro_valid, copro_accept} !== 2'b00) begin
      failures++; $display("FAIL rst_copro_hs: got %b want 00", {copro_valid, copro_accept});
    end
    checks++;
    if ({copro_opcode, copro_op0, copro_op1} !== 75'd0) begin
      failures++; $display("FAIL rst_copro_bus: got %h/%h/%h want 0", copro_opcode, copro_op0, copro_op1);
    end
    rst_n = 1'b1;
    repeat (T_MAX - 1) tick();
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++; $display("FAIL flush_hold: cpu_ready=%0b want 0", cpu_ready);
    end
    tick();
    checks++;
    if (cpu_ready !== 1'b1) begin
      failures++; $display("FAIL flush_end: cpu_ready=%0b want 1", cpu_ready);
    end
  endtask

  task automatic test_add();
    int v0 = n_val;
    int a0 = n_acc;
    int lat;
    res_ready = 1'b0;
    push(11'd0, 32'h3F800000, 32'h40000000);
    wait_res(lat);
    checks++;
    if (res_data !== 32'h40400000 || res_err !== 1'b0) begin
      failures++; $display("FAIL add_result: got %h err=%0b want 40400000 err=0", res_data, res_err);
    end
    checks++;
    if (lat != 7) begin
      failures++; $display("FAIL add_latency: got %0d want 7", lat);
    end
    checks++;
    if (n_val - v0 != 1) begin
      failures++; $display("FAIL add_valid_pulses: got %0d want 1", n_val - v0);
    end
    checks++;
    if (n_acc - a0 != 1) begin
      failures++; $display("FAIL add_accept_cycles: got %0d want 1", n_acc - a0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0) begin
      failures++; $display("FAIL add_consume: res_valid=%0b want 0", res_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [2];
    logic [31:0] exp [2];
    int v0 = n_val;
    int k = 0;
    int n = 0;
    exp[0] = 32'h40000000;
    exp[1] = 32'h41000000;
    res_ready = 1'b1;
    push(11'd1, 32'h40A00000, 32'h40400000);
    push(11'd2, 32'h40000000, 32'h40800000);
    while (k < 2 && n < 100) begin
      if (res_valid) begin
        got[k] = res_data;
        k++;
      end
      tick();
      n++;
    end
    res_ready = 1'b0;
    checks++;
    if (k != 2) begin
      failures++; $display("FAIL b2b_count: got %0d results want 2", k);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++; $display("FAIL b2b_result%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
    checks++;
    if (n_val - v0 != 2 || n_viol != 0) begin
      failures++; $display("FAIL b2b_issue: pulses=%0d viol=%0d want 2/0", n_val - v0, n_viol);
    end
  endtask

  task automatic test_fifo_full();
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [31:0] exp [5];
    logic [31:0] got [5];
    int k = 0;
    int n = 0;
    a[0] = 32'h3F800000; b[0] = 32'h3F800000; exp[0] = 32'h40000000;
    a[1] = 32'h3F800000; b[1] = 32'h40000000; exp[1] = 32'h40400000;
    a[2] = 32'h40000000; b[2] = 32'h40000000; exp[2] = 32'h40800000;
    a[3] = 32'h40000000; b[3] = 32'h40800000; exp[3] = 32'h40C00000;
    a[4] = 32'h40800000; b[4] = 32'h40800000; exp[4] = 32'h41000000;
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push(11'd0, a[i], b[i]);
    checks++;
    if (cpu_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready: cpu_ready=%0b want 0", cpu_ready);
    end
    repeat (20) tick();
    checks++;
    if (cpu_ready !== 1'b0 || res_valid !== 1'b1 || res_data !== exp[0]) begin
      failures++; $display("FAIL full_hold: ready=%0b v=%0b d=%h want 0/1/%h", cpu_ready, res_valid, res_data, exp[0]);
    end
    res_ready = 1'b1;
    while (k < 5 && n < 200) begin
      if (res_valid) begin
        got[k] = res_data;
        k++;
      end
      tick();
      n++;
    end
    res_ready = 1'b0;
    checks++;
    if (k != 5) begin
      failures++; $display("FAIL full_count: got %0d results want 5", k);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        failures++; $display("FAIL full_result%0d: got %h want %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    int v0 = n_val;
    res_ready = 1'b0;
    push(11'd7, 32'h3F800000, 32'h3F800000);
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_err !== 1'b1 || res_data !== 32'd0) begin
      failures++; $display("FAIL illegal_result: v=%0b e=%0b d=%h want 1/1/0", res_valid, res_err, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || res_err !== 1'b0) begin
      failures++; $display("FAIL illegal_consume: v=%0b e=%0b want 0/0", res_valid, res_err);
    end
    checks++;
    if (n_val != v0) begin
      failures++; $display("FAIL illegal_no_issue: pulses=%0d want 0", n_val - v0);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int a0;
    int lat;
    logic seen = 1'b0;
    cp_lat = 6;
    res_ready = 1'b1;
    push(11'd2, 32'h40000000, 32'h40800000);
    while (!copro_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!copro_valid) begin
      failures++; $display("FAIL mid_issue: copro_valid=0 want 1");
    end
    tick();
    a0 = n_acc;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (copro_opcode !== 11'd0 || cpu_ready !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state: op=%h ready=%0b want 0/0", copro_opcode, cpu_ready);
    end
    for (int i = 0; i < T_MAX + 4; i++) begin
      if (res_valid) seen = 1'b1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++; $display("FAIL mid_no_result: res_valid seen=%0b want 0", seen);
    end
    checks++;
    if (n_acc - a0 != 1 || copro_complete !== 1'b0) begin
      failures++; $display("FAIL mid_drain: accepts=%0d complete=%0b want 1/0", n_acc - a0, copro_complete);
    end
    cp_lat = 3;
    res_ready = 1'b0;
    push(11'd0, 32'h40000000, 32'h40000000);
    wait_res(lat);
    checks++;
    if (res_data !== 32'h40800000 || res_err !== 1'b0) begin
      failures++; $display("FAIL mid_next_add: got %h err=%0b want 40800000 err=0", res_data, res_err);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_fifo_full();
    test_illegal();
    test_reset_mid();
    checks++;
    if (n_viol != 0) begin
      failures++; $display("FAIL handshake_overlap: violations=%0d want 0", n_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/float_copro_dispatch.md
Name: float_copro_dispatch

Overview:
- Upstream front-end of the float coprocessor. It sits between the LM32 custom-instruction port and `float_copro`.
- Buffers CPU requests in a small FIFO and issues them one at a time on the copro valid/complete/accept handshake.
- Captures each result and returns it to the CPU over a valid/ready channel.
- Rejects opcodes the coprocessor does not implement, so the coprocessor can never hang.

Parameters:
- DEPTH, 4, request FIFO entries (power of 2, ≥2)
- T_MAX, 8, cycles to hold the post-reset flush window (≥ largest copro latency + 2)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cpu_valid  in  1  request present
- cpu_ready  out  1  FIFO not full
- cpu_opcode  in  11  operation: 0=add, 1=sub, 2=mul
- cpu_op0  in  32  operand 0 (IEEE-754 single)
- cpu_op1  in  32  operand 1
- res_valid  out  1  result present
- res_ready  in  1  CPU takes result
- res_data  out  32  result
- res_err  out  1  illegal opcode; res_data=0
- copro_valid  out  1  issue strobe
- copro_opcode  out  11  to copro
- copro_op0  out  32  to copro
- copro_op1  out  32  to copro
- copro_complete  in  1  copro result valid (level, held until accept)
- copro_result  in  32  copro result
- copro_accept  out  1  result consumed

Behaviour:
- Clock and reset (already decided): one clock `clk`; reset is synchronous and active-low on `rst_n`.
- Reset values: cpu_ready=0, res_valid=0, res_err=0, res_data=0, copro_valid=0, copro_accept=0, copro_opcode/op0/op1=0. FIFO empty. State=FLUSH.
- FIFO:
  - Push when cpu_valid&&cpu_ready.
  - cpu_ready=!full, except forced 0 in FLUSH.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - Requests are issued in order.
- FSM transitions:
  - FLUSH:
    - Counter runs T_MAX cycles.
    - copro_accept pulses one cycle whenever copro_complete=1 and accept was 0 last cycle. The copro has no reset, so this drains any stale result; that result is discarded.
    - Then go to IDLE.
  - IDLE, FIFO not empty, opcode ≤2:
    - Pop the entry and drive copro_opcode/op0/op1 from it.
    - copro_valid=1 for exactly one cycle (ISSUE).
    - Then go to WAIT.
  - IDLE, FIFO not empty, opcode >2:
    - Pop the entry; do not touch the copro.
    - Set res_valid=1, res_err=1, res_data=0.
    - Go to RET.
  - WAIT:
    - copro_valid=0; copro_opcode/op0/op1 held stable.
    - On copro_complete=1: latch copro_result into res_data, pulse copro_accept for one cycle, go to ACK.
  - ACK:
    - One cycle, copro_accept=0; lets copro_complete fall.
    - Set res_valid=1, res_err=0, go to RET.
  - RET:
    - Hold res_valid/res_data/res_err until res_ready=1.
    - Then clear res_valid and go to IDLE.
- Ordering rules:
  - copro_valid and copro_accept are never high in the same cycle.
  - copro_valid is never asserted while copro_complete=1.
  - At most one operation is outstanding.
- Latency: accepted request to res_valid = 1 (pop/issue) + copro latency + 2 (accept, ACK) when the FIFO is empty. Illegal opcode: 1 cycle.
- Reset mid-operation: state forced to FLUSH and the FIFO cleared. The in-flight result is drained in FLUSH and never returned.
- copro_complete while not in WAIT or FLUSH is a protocol error: ignored (assertion in bench).

Optional Feature:
- DISPATCH_TIMEOUT_EN defined:
  - 8-bit watchdog counts WAIT cycles.
  - At 255 the FSM returns res_valid=1, res_err=1, res_data=32'h7FC00000 (qNaN) and goes to FLUSH (the copro result is discarded).
- Undefined: WAIT has no time limit; the counter is not instantiated.

Decomposition:
- Package `float_copro_pkg`:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_MAX=2.
  - State enum {FLUSH, IDLE, ISSUE, WAIT, ACK, RET}.
  - QNAN constant.
  - Request struct {opcode, op0, op1}.
- Sub-module `copro_req_fifo` (parameterised DEPTH, struct payload, push/pop/full/empty). The FSM stays in the top.

Test Plan:
- Post-reset: rst_n low 2 cycles → all outputs 0; cpu_ready rises after T_MAX cycles.
- ADD 1.0+2.0 (3F800000, 40000000) → copro_valid pulses once; res_data=40400000, res_err=0; copro_accept exactly one cycle.
- Back-to-back: push SUB 5.0-3.0 and MUL 2.0*4.0 in consecutive cycles → results 40000000 then 41000000, in order, no overlap of copro_valid.
- Push DEPTH+1 requests with res_ready=0 → cpu_ready low at full; after res_ready=1 all DEPTH+1 results return in order.
- Opcode 7 → res_err=1, res_data=0 one cycle after pop; copro_valid never asserted.
- Reset during WAIT of a MUL → no result returned; stale copro_complete accepted in FLUSH; a following ADD returns its correct result.
